// File: rtl/hlsm_rr_scheduler.sv
// Round-robin front end for one shared HLSM compute unit: arbitrates among
// requesters, captures the winner's operands, starts the datapath, waits for
// completion (with timeout) and routes the result back to the winner.
module hlsm_rr_scheduler #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned DW      = 16,
   parameter int unsigned ZW      = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] op_a,
   input  logic [N_REQ*DW-1:0] op_b,
   input  logic [N_REQ*DW-1:0] op_c,
   output logic [N_REQ-1:0]    ack,
   output logic [N_REQ-1:0]    rsp_valid,
   output logic [ZW-1:0]       rsp_z,
   output logic [DW-1:0]       rsp_x,
   output logic                rsp_err,
   output logic                busy,
   output logic                dp_start,
   output logic [DW-1:0]       dp_a,
   output logic [DW-1:0]       dp_b,
   output logic [DW-1:0]       dp_c,
   input  logic                dp_done,
   input  logic [ZW-1:0]       dp_z,
   input  logic [DW-1:0]       dp_x
);

   localparam int unsigned IW = $clog2(N_REQ);
   localparam int unsigned TW = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     win_q, win_d;
   logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [ZW-1:0]     rsp_z_q, rsp_z_d;
   logic [DW-1:0]     rsp_x_q, rsp_x_d;
   logic              rsp_err_q, rsp_err_d;
   logic              busy_q, busy_d;
   logic              dp_start_q, dp_start_d;
   logic [DW-1:0]     dp_a_q, dp_a_d;
   logic [DW-1:0]     dp_b_q, dp_b_d;
   logic [DW-1:0]     dp_c_q, dp_c_d;

   logic [IW-1:0]     pick_idx;
   logic [IW-1:0]     cand;
   logic              pick_found;

   // Round-robin search: first requester set starting at ptr, wrapping modulo N_REQ.
   always_comb begin
      pick_idx   = '0;
      pick_found = 1'b0;
      cand       = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = IW'((32'(ptr_q) + i) % N_REQ);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Next-state and registered-output logic for IDLE -> START -> WAIT -> RESP.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      tmo_cnt_d   = tmo_cnt_q;
      ack_d       = '0;
      rsp_valid_d = '0;
      rsp_z_d     = rsp_z_q;
      rsp_x_d     = rsp_x_q;
      rsp_err_d   = rsp_err_q;
      dp_start_d  = 1'b0;
      dp_a_d      = dp_a_q;
      dp_b_d      = dp_b_q;
      dp_c_d      = dp_c_q;

      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               win_d           = pick_idx;
               dp_a_d          = op_a[pick_idx*DW +: DW];
               dp_b_d          = op_b[pick_idx*DW +: DW];
               dp_c_d          = op_c[pick_idx*DW +: DW];
               ack_d[pick_idx] = 1'b1;
               dp_start_d      = 1'b1;
               state_d         = S_START;
            end
         end
         S_START: begin
            tmo_cnt_d = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (dp_done) begin
               rsp_z_d            = dp_z;
               rsp_x_d            = dp_x;
               rsp_err_d          = 1'b0;
               rsp_valid_d[win_q] = 1'b1;
               state_d            = S_RESP;
            end else if ((32'(tmo_cnt_q) + 32'd1) >= TIMEOUT) begin
               // Abort: zeroed result flagged as error.
               rsp_z_d            = '0;
               rsp_x_d            = '0;
               rsp_err_d          = 1'b1;
               rsp_valid_d[win_q] = 1'b1;
               tmo_cnt_d          = tmo_cnt_q + 1'b1;
               state_d            = S_RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            ptr_d   = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; async active-low reset clears everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         win_q       <= '0;
         tmo_cnt_q   <= '0;
         ack_q       <= '0;
         rsp_valid_q <= '0;
         rsp_z_q     <= '0;
         rsp_x_q     <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         dp_start_q  <= 1'b0;
         dp_a_q      <= '0;
         dp_b_q      <= '0;
         dp_c_q      <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         tmo_cnt_q   <= tmo_cnt_d;
         ack_q       <= ack_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_z_q     <= rsp_z_d;
         rsp_x_q     <= rsp_x_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         dp_start_q  <= dp_start_d;
         dp_a_q      <= dp_a_d;
         dp_b_q      <= dp_b_d;
         dp_c_q      <= dp_c_d;
      end
   end

   assign ack       = ack_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_z     = rsp_z_q;
   assign rsp_x     = rsp_x_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;
   assign dp_start  = dp_start_q;
   assign dp_a      = dp_a_q;
   assign dp_b      = dp_b_q;
   assign dp_c      = dp_c_q;

endmodule

// File: tb/tb_hlsm_rr_scheduler.sv
// Bench for hlsm_rr_scheduler: behavioural datapath model plus a scoreboard of
// expected responses pushed when requests are driven.
module tb_hlsm_rr_scheduler;

   localparam int unsigned N   = 4;
   localparam int unsigned DW  = 16;
   localparam int unsigned ZW  = 8;
   localparam int unsigned TMO = 15;
   localparam int unsigned LAT = 5;
   localparam int unsigned RW  = N + ZW + DW + 1;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*DW-1:0] op_a, op_b, op_c;
   logic [N-1:0]    ack, rsp_valid;
   logic [ZW-1:0]   rsp_z;
   logic [DW-1:0]   rsp_x;
   logic            rsp_err, busy, dp_start;
   logic [DW-1:0]   dp_a, dp_b, dp_c;
   logic            dp_done, model_done, force_done, dp_en;
   logic [ZW-1:0]   dp_z;
   logic [DW-1:0]   dp_x;

   assign dp_done = model_done | force_done;

   typedef struct packed {
      logic [N-1:0]  sel;
      logic [ZW-1:0] z;
      logic [DW-1:0] x;
      logic          err;
   } exp_t;

   exp_t sbq[$];
   int   vectors     = 0;
   int   miscompares = 0;

   hlsm_rr_scheduler #(.N_REQ(N), .DW(DW), .ZW(ZW), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_c      (op_c),
      .ack       (ack),
      .rsp_valid (rsp_valid),
      .rsp_z     (rsp_z),
      .rsp_x     (rsp_x),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .dp_start  (dp_start),
      .dp_a      (dp_a),
      .dp_b      (dp_b),
      .dp_c      (dp_c),
      .dp_done   (dp_done),
      .dp_z      (dp_z),
      .dp_x      (dp_x)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [ZW-1:0] fz(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [DW-1:0] c);
      logic [DW-1:0] s1, s2;
      s1 = a + b;
      s2 = a + c;
      return ZW'((s1 > s2) ? s1 : s2);
   endfunction

   function automatic logic [DW-1:0] fx(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [DW-1:0] c);
      logic [DW-1:0] p, s;
      p = DW'(a * c);
      s = DW'(a + b);
      return p - s;
   endfunction

   function automatic exp_t mk(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [DW-1:0] c);
      exp_t e;
      e = '0;
      e.sel[idx] = 1'b1;
      e.z = fz(a, b, c);
      e.x = fx(a, b, c);
      return e;
   endfunction

   function automatic exp_t mk_err(input int idx);
      exp_t e;
      e = '0;
      e.sel[idx] = 1'b1;
      e.err = 1'b1;
      return e;
   endfunction

   // Shared datapath model: done LAT cycles after the start pulse (when enabled).
   initial begin
      int            cnt;
      logic [DW-1:0] ma, mb, mc;
      cnt = 0; ma = '0; mb = '0; mc = '0;
      model_done = 1'b0; dp_z = '0; dp_x = '0;
      forever begin
         @(negedge clk);
         model_done = 1'b0;
         if (!rst) cnt = 0;
         else if (dp_start) begin
            cnt = LAT; ma = dp_a; mb = dp_b; mc = dp_c;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && dp_en) begin
               model_done = 1'b1;
               dp_z = fz(ma, mb, mc);
               dp_x = fx(ma, mb, mc);
            end
         end
      end
   end

   task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c);
      op_a[i*DW +: DW] = a;
      op_b[i*DW +: DW] = b;
      op_c[i*DW +: DW] = c;
   endtask

   task automatic wait_ack(output logic [N-1:0] v, output int n);
      v = '0; n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (|ack) begin v = ack; n = k; return; end
      end
   endtask

   task automatic wait_rsp(output logic [RW-1:0] v, output int n);
      v = '0; n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (|rsp_valid) begin v = {rsp_valid, rsp_z, rsp_x, rsp_err}; n = k; return; end
      end
   endtask

   function automatic exp_t pop_exp();
      if (sbq.size() == 0) return '0;
      return sbq.pop_front();
   endfunction

   task automatic test_reset;
      rst = 1'b0; req = '0; op_a = '0; op_b = '0; op_c = '0;
      force_done = 1'b0; dp_en = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({ack, rsp_valid, busy, dp_start} !== '0) begin
         miscompares++;
         $display("FAIL reset_ctrl got=%b exp=0", {ack, rsp_valid, busy, dp_start});
      end
      vectors++;
      if ({rsp_z, rsp_x, rsp_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_rsp got=%h exp=0", {rsp_z, rsp_x, rsp_err});
      end
      vectors++;
      if ({dp_a, dp_b, dp_c} !== '0) begin
         miscompares++;
         $display("FAIL reset_dp got=%h exp=0", {dp_a, dp_b, dp_c});
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, ack} !== '0) begin
         miscompares++;
         $display("FAIL reset_idle got=%b exp=0", {busy, ack});
      end
   endtask

   task automatic test_round_robin;
      logic [N-1:0]  v;
      logic [RW-1:0] r;
      exp_t          e;
      int            n;
      for (int i = 0; i < int'(N); i++) begin
         set_op(i, 16'(10 + 3*i), 16'(2 + i), 16'(30 - 4*i));
         sbq.push_back(mk(i, 16'(10 + 3*i), 16'(2 + i), 16'(30 - 4*i)));
      end
      sbq.push_back(mk(0, 16'd77, 16'd5, 16'd6));
      req = '1;
      for (int k = 0; k <= int'(N); k++) begin
         wait_ack(v, n);
         vectors++;
         if (v !== N'(1 << (k % int'(N)))) begin
            miscompares++;
            $display("FAIL rr_ack%0d got=%b exp=%b", k, v, N'(1 << (k % int'(N))));
         end
         if (k > 0) begin
            vectors++;
            if (n !== 2) begin
               miscompares++;
               $display("FAIL rr_gap%0d got=%0d exp=2", k, n);
            end
         end
         if (k == 0) set_op(0, 16'd77, 16'd5, 16'd6);
         if (k == int'(N)) req = '0;
         wait_rsp(r, n);
         e = pop_exp();
         vectors++;
         if (r !== e) begin
            miscompares++;
            $display("FAIL rr_rsp%0d got=%h exp=%h", k, r, e);
         end
      end
   endtask

   task automatic test_single;
      logic [N-1:0]  v;
      logic [RW-1:0] r;
      exp_t          e;
      int            n;
      set_op(0, 16'd3, 16'd4, 16'd5);
      sbq.push_back(mk(0, 16'd3, 16'd4, 16'd5));
      req = 4'b0001;
      wait_ack(v, n);
      vectors++;
      if (v !== 4'b0001) begin
         miscompares++;
         $display("FAIL single_ack got=%b exp=0001", v);
      end
      vectors++;
      if ({dp_start, dp_a, dp_b, dp_c} !== {1'b1, 16'd3, 16'd4, 16'd5}) begin
         miscompares++;
         $display("FAIL single_start got=%h exp=%h", {dp_start, dp_a, dp_b, dp_c},
                  {1'b1, 16'd3, 16'd4, 16'd5});
      end
      req = '0;
      @(negedge clk);
      vectors++;
      if ({ack, dp_start} !== '0) begin
         miscompares++;
         $display("FAIL single_pulse got=%b exp=0", {ack, dp_start});
      end
      wait_rsp(r, n);
      vectors++;
      if (n !== 5) begin
         miscompares++;
         $display("FAIL single_lat got=%0d exp=5", n);
      end
      e = pop_exp();
      vectors++;
      if (r !== e) begin
         miscompares++;
         $display("FAIL single_rsp got=%h exp=%h", r, e);
      end
      vectors++;
      if ({rsp_z, rsp_x, rsp_err} !== {8'd8, 16'd8, 1'b0}) begin
         miscompares++;
         $display("FAIL single_val got=%h exp=%h", {rsp_z, rsp_x, rsp_err}, {8'd8, 16'd8, 1'b0});
      end
      @(negedge clk);
      vectors++;
      if ({rsp_valid, busy, rsp_z} !== {4'b0000, 1'b0, 8'd8}) begin
         miscompares++;
         $display("FAIL single_hold got=%h exp=%h", {rsp_valid, busy, rsp_z}, {4'b0000, 1'b0, 8'd8});
      end
   endtask

   task automatic test_timeout;
      logic [N-1:0]  v;
      logic [RW-1:0] r;
      exp_t          e;
      int            n;
      dp_en = 1'b0;
      set_op(1, 16'd7, 16'd2, 16'd9);
      sbq.push_back(mk_err(1));
      req = 4'b0010;
      wait_ack(v, n);
      vectors++;
      if (v !== 4'b0010) begin
         miscompares++;
         $display("FAIL tmo_ack got=%b exp=0010", v);
      end
      req = '0;
      wait_rsp(r, n);
      vectors++;
      if (n !== int'(TMO) + 1) begin
         miscompares++;
         $display("FAIL tmo_lat got=%0d exp=%0d", n, TMO + 1);
      end
      e = pop_exp();
      vectors++;
      if (r !== e) begin
         miscompares++;
         $display("FAIL tmo_rsp got=%h exp=%h", r, e);
      end
      dp_en = 1'b1;
      set_op(1, 16'd12, 16'd1, 16'd4);
      sbq.push_back(mk(1, 16'd12, 16'd1, 16'd4));
      req = 4'b0010;
      wait_ack(v, n);
      req = '0;
      wait_rsp(r, n);
      vectors++;
      if (n !== int'(LAT) + 1) begin
         miscompares++;
         $display("FAIL tmo_next_lat got=%0d exp=%0d", n, LAT + 1);
      end
      e = pop_exp();
      vectors++;
      if (r !== e) begin
         miscompares++;
         $display("FAIL tmo_next_rsp got=%h exp=%h", r, e);
      end
   endtask

   task automatic test_ignore;
      logic [N-1:0]  v, seen;
      logic [RW-1:0] r;
      exp_t          e;
      int            n;
      logic          bseen;
      force_done = 1'b1;
      seen = '0; bseen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         force_done = 1'b0;
         seen |= rsp_valid | ack;
         bseen |= busy;
      end
      vectors++;
      if ({seen, bseen} !== '0) begin
         miscompares++;
         $display("FAIL ign_idle got=%b exp=0", {seen, bseen});
      end
      set_op(2, 16'd20, 16'd6, 16'd11);
      sbq.push_back(mk(2, 16'd20, 16'd6, 16'd11));
      req = 4'b0100;
      wait_ack(v, n);
      vectors++;
      if (v !== 4'b0100) begin
         miscompares++;
         $display("FAIL ign_ack got=%b exp=0100", v);
      end
      @(negedge clk);
      req = 4'b1011;
      set_op(2, 16'd99, 16'd99, 16'd99);
      @(negedge clk);
      req = 4'b1111;
      @(negedge clk);
      vectors++;
      if ({dp_a, dp_b, dp_c} !== {16'd20, 16'd6, 16'd11}) begin
         miscompares++;
         $display("FAIL ign_hold got=%h exp=%h", {dp_a, dp_b, dp_c}, {16'd20, 16'd6, 16'd11});
      end
      req = '0;
      wait_rsp(r, n);
      e = pop_exp();
      vectors++;
      if (r !== e) begin
         miscompares++;
         $display("FAIL ign_rsp got=%h exp=%h", r, e);
      end
      force_done = 1'b1;
      seen = '0; bseen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         force_done = 1'b0;
         seen |= rsp_valid | ack;
         if (k > 0) bseen |= busy;
      end
      vectors++;
      if ({seen, bseen} !== '0) begin
         miscompares++;
         $display("FAIL ign_resp got=%b exp=0", {seen, bseen});
      end
   endtask

   task automatic test_wrap;
      logic [N-1:0]  v;
      logic [RW-1:0] r;
      exp_t          e;
      int            n;
      set_op(3, 16'd8, 16'd1, 16'd2);
      set_op(0, 16'd5, 16'd5, 16'd5);
      sbq.push_back(mk(3, 16'd8, 16'd1, 16'd2));
      sbq.push_back(mk(0, 16'd5, 16'd5, 16'd5));
      req = 4'b1001;
      wait_ack(v, n);
      vectors++;
      if (v !== 4'b1000) begin
         miscompares++;
         $display("FAIL wrap_ack0 got=%b exp=1000", v);
      end
      wait_rsp(r, n);
      e = pop_exp();
      vectors++;
      if (r !== e) begin
         miscompares++;
         $display("FAIL wrap_rsp0 got=%h exp=%h", r, e);
      end
      wait_ack(v, n);
      vectors++;
      if (v !== 4'b0001) begin
         miscompares++;
         $display("FAIL wrap_ack1 got=%b exp=0001", v);
      end
      req = '0;
      wait_rsp(r, n);
      e = pop_exp();
      vectors++;
      if (r !== e) begin
         miscompares++;
         $display("FAIL wrap_rsp1 got=%h exp=%h", r, e);
      end
   endtask

   task automatic test_reset_midop;
      logic [N-1:0]  v, seen;
      logic [RW-1:0] r;
      exp_t          e;
      int            n;
      logic          bseen;
      dp_en = 1'b0;
      set_op(2, 16'd40, 16'd3, 16'd2);
      req = 4'b0100;
      wait_ack(v, n);
      req = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_busy got=%b exp=1", busy);
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      force_done = 1'b1;
      #1;
      vectors++;
      if ({busy, dp_start, ack, rsp_valid, rsp_err} !== '0) begin
         miscompares++;
         $display("FAIL async_ctrl got=%b exp=0", {busy, dp_start, ack, rsp_valid, rsp_err});
      end
      vectors++;
      if ({dp_a, dp_b, dp_c, rsp_z, rsp_x} !== '0) begin
         miscompares++;
         $display("FAIL async_data got=%h exp=0", {dp_a, dp_b, dp_c, rsp_z, rsp_x});
      end
      repeat (2) @(negedge clk);
      force_done = 1'b0;
      rst = 1'b1;
      dp_en = 1'b1;
      seen = '0; bseen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         seen |= rsp_valid | ack;
         bseen |= busy;
      end
      vectors++;
      if ({seen, bseen} !== '0) begin
         miscompares++;
         $display("FAIL post_reset_quiet got=%b exp=0", {seen, bseen});
      end
      set_op(0, 16'd2, 16'd9, 16'd1);
      set_op(3, 16'd6, 16'd6, 16'd6);
      sbq.push_back(mk(0, 16'd2, 16'd9, 16'd1));
      req = 4'b1001;
      wait_ack(v, n);
      vectors++;
      if (v !== 4'b0001) begin
         miscompares++;
         $display("FAIL ptr_reset got=%b exp=0001", v);
      end
      req = '0;
      wait_rsp(r, n);
      e = pop_exp();
      vectors++;
      if (r !== e) begin
         miscompares++;
         $display("FAIL post_reset_rsp got=%h exp=%h", r, e);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_timeout();
      test_ignore();
      test_wrap();
      test_reset_midop();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of sequence");
      $fatal(1);
   end

endmodule
